inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Inverse of the instruction decoder: accepts one decoded op (`INST_TYPE code, rd, rs1, rs2,
//  sign-extended imm) per handshake and packs it into a 32-bit RV32I word.
//  Writes the word little-endian into byte-wide RAM over 4 cycles at an auto-incrementing address.
//  Used by the boot loader / self-test harness to fill instruction memory.
// PARAMETERS
//  ADDR_WIDTH  32  width of memory address and write pointer
//  BASE_ADDR   0   write-pointer value after reset
// PORTS
//  clk_in     in   1            clock, all state on rising edge
//  rstn_in    in   1            asynchronous reset, active low
//  in_valid   in   1            decoded op presented
//  in_ready   out  1            op accepted when in_valid&&in_ready
//  in_type    in   `INST_TYPE_WIDTH  op code (`LUI..`AND as in info.v)
//  in_rd      in   5            destination register
//  in_rs1     in   5            source register 1
//  in_rs2     in   5            source register 2
//  in_imm     in   32           immediate, sign-extended as the decoder produces it
//  addr_load  in   1            load write pointer from addr_val (IDLE only)
//  addr_val   in   ADDR_WIDTH   new write pointer
//  mem_stall  in   1            RAM busy; hold current byte
//  mem_a      out  ADDR_WIDTH   byte address
//  mem_dout   out  8            byte data
//  mem_wr     out  1            byte write strobe
//  done       out  1            one-cycle pulse with the 4th byte write
//  err        out  1            one-cycle pulse, illegal op dropped (ENCODE_CHECK_EN only, else 0)
// BEHAVIOUR
//  Reset: state=IDLE, ptr=BASE_ADDR, in_ready=1, mem_wr=0, mem_a=0, mem_dout=0, done=0, err=0.
//  FSM IDLE -> WRITE(byte k=0..3) -> IDLE. in_ready=1 only in IDLE.
//  IDLE: addr_load has priority; ptr<=addr_val the same edge, and an op accepted in that
//   cycle is written at addr_val. On accept: latch word, base=ptr, k=0, go WRITE.
//  WRITE: mem_wr=1, mem_a=base+k, mem_dout=word[8k+7:8k]. If mem_stall, hold k and outputs.
//   Otherwise k++. When k=3 and not stalled: done=1, ptr<=base+4, go IDLE.
//  Latency: accept at edge 0; bytes at cycles 1..4 (no stall); next accept at cycle 5.
//  ptr wraps modulo 2^ADDR_WIDTH; a byte address base+k wraps likewise.
//  addr_load outside IDLE is ignored. Reset mid-write aborts; partial bytes remain in RAM.
//  Encoding (opcode/funct3/funct7 per RV32I):
//   U: {imm[31:12],rd,op}. J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
//   I/load/JALR: {imm[11:0],rs1,f3,rd,op}. SLLI/SRLI/SRAI: {f7,imm[4:0],rs1,f3,rd,op},
//   f7=0x20 for SRAI regardless of imm[10]. S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
//   B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}. R: f7=0x20 for SUB/SRA.
//  Encoding is combinational from the in_* ports; the word is registered at accept.
// CONFIGURATION
//  ENCODE_CHECK_EN defined: at accept, an unknown in_type is illegal, as is an imm not
//   representable in its field: I/S outside [-2048,2047]; B outside [-4096,4094] or odd;
//   J outside +-1 MiB or odd; U with imm[11:0]!=0; shift amount >31.
//   An illegal op is consumed: err=1 for one cycle, no bytes written, ptr unchanged,
//   stays in IDLE.
//  Undefined: no checks. The imm is truncated to its field. An unknown type encodes as
//   0x00000013 (NOP) and is written normally. err is tied to 0.
// TESTING
//  ADDI rd=1,rs1=0,imm=-1 after reset -> bytes 93,00,F0,FF at 0..3, done with 4th byte.
//  LUI rd=5,imm=0x12345000, then addr_load=0x100 -> word 0x123452B7 at 0x100..0x103.
//  SRAI rd=3,rs1=3,imm=4 (imm[10]=0) -> 0x4041D193; BEQ rs1=1,rs2=2,imm=-8 -> 0xFE208CE3.
//  mem_stall high 3 cycles on byte 2 -> mem_a/mem_dout held, done delayed 3 cycles,
//   in_ready low throughout.
//  Reset asserted on byte 1 -> outputs return to reset values immediately, ptr=BASE_ADDR.
//  ENCODE_CHECK_EN: ADDI imm=2048 -> err pulse, no mem_wr; next op writes at the old ptr.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs one decoded op per handshake into a 32-bit word and
// writes it little-endian into byte-wide RAM. Define ENCODE_CHECK_EN to reject unencodable ops.
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 6
`endif

package inst_encoder_pkg;
  localparam int TYPE_W = `INST_TYPE_WIDTH;

  // Op codes follow the decoder's numbering, LUI first through AND; everything else is unknown.
  typedef enum logic [TYPE_W-1:0] {
    OP_LUI = TYPE_W'(1), OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } inst_type_e;

  typedef enum logic [2:0] {F_U, F_J, F_I, F_SH, F_S, F_B, F_R, F_BAD} fmt_e;
  typedef enum logic {S_IDLE, S_WRITE} state_e;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
endpackage

module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                        clk_in,
  input  logic                        rstn_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [`INST_TYPE_WIDTH-1:0] in_type,
  input  logic [4:0]                  in_rd,
  input  logic [4:0]                  in_rs1,
  input  logic [4:0]                  in_rs2,
  input  logic [31:0]                 in_imm,
  input  logic                        addr_load,
  input  logic [ADDR_WIDTH-1:0]       addr_val,
  input  logic                        mem_stall,
  output logic [ADDR_WIDTH-1:0]       mem_a,
  output logic [7:0]                  mem_dout,
  output logic                        mem_wr,
  output logic                        done,
  output logic                        err
);

  state_e                state, state_d;
  logic [1:0]            k;
  logic [31:0]           word;
  logic [ADDR_WIDTH-1:0] base, ptr;
  fmt_e                  fmt;
  logic [6:0]            opc;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [31:0]           enc;
  logic                  illegal;
  logic                  accept;

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    fmt = F_BAD;
    opc = OPC_IMM;
    f3  = 3'd0;
    f7  = 7'h00;
    case (in_type)
      OP_LUI:   begin fmt = F_U;  opc = OPC_LUI;    end
      OP_AUIPC: begin fmt = F_U;  opc = OPC_AUIPC;  end
      OP_JAL:   begin fmt = F_J;  opc = OPC_JAL;    end
      OP_JALR:  begin fmt = F_I;  opc = OPC_JALR;   f3 = 3'd0; end
      OP_BEQ:   begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'd0; end
      OP_BNE:   begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'd1; end
      OP_BLT:   begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'd4; end
      OP_BGE:   begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'd5; end
      OP_BLTU:  begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'd6; end
      OP_BGEU:  begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'd7; end
      OP_LB:    begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'd0; end
      OP_LH:    begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'd1; end
      OP_LW:    begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'd2; end
      OP_LBU:   begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'd4; end
      OP_LHU:   begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'd5; end
      OP_SB:    begin fmt = F_S;  opc = OPC_STORE;  f3 = 3'd0; end
      OP_SH:    begin fmt = F_S;  opc = OPC_STORE;  f3 = 3'd1; end
      OP_SW:    begin fmt = F_S;  opc = OPC_STORE;  f3 = 3'd2; end
      OP_ADDI:  begin fmt = F_I;  opc = OPC_IMM;    f3 = 3'd0; end
      OP_SLTI:  begin fmt = F_I;  opc = OPC_IMM;    f3 = 3'd2; end
      OP_SLTIU: begin fmt = F_I;  opc = OPC_IMM;    f3 = 3'd3; end
      OP_XORI:  begin fmt = F_I;  opc = OPC_IMM;    f3 = 3'd4; end
      OP_ORI:   begin fmt = F_I;  opc = OPC_IMM;    f3 = 3'd6; end
      OP_ANDI:  begin fmt = F_I;  opc = OPC_IMM;    f3 = 3'd7; end
      OP_SLLI:  begin fmt = F_SH; opc = OPC_IMM;    f3 = 3'd1; end
      OP_SRLI:  begin fmt = F_SH; opc = OPC_IMM;    f3 = 3'd5; end
      OP_SRAI:  begin fmt = F_SH; opc = OPC_IMM;    f3 = 3'd5; f7 = 7'h20; end
      OP_ADD:   begin fmt = F_R;  opc = OPC_OP;     f3 = 3'd0; end
      OP_SUB:   begin fmt = F_R;  opc = OPC_OP;     f3 = 3'd0; f7 = 7'h20; end
      OP_SLL:   begin fmt = F_R;  opc = OPC_OP;     f3 = 3'd1; end
      OP_SLT:   begin fmt = F_R;  opc = OPC_OP;     f3 = 3'd2; end
      OP_SLTU:  begin fmt = F_R;  opc = OPC_OP;     f3 = 3'd3; end
      OP_XOR:   begin fmt = F_R;  opc = OPC_OP;     f3 = 3'd4; end
      OP_SRL:   begin fmt = F_R;  opc = OPC_OP;     f3 = 3'd5; end
      OP_SRA:   begin fmt = F_R;  opc = OPC_OP;     f3 = 3'd5; f7 = 7'h20; end
      OP_OR:    begin fmt = F_R;  opc = OPC_OP;     f3 = 3'd6; end
      OP_AND:   begin fmt = F_R;  opc = OPC_OP;     f3 = 3'd7; end
      default:  fmt = F_BAD;
    endcase
  end

  always_comb begin
    case (fmt)
      F_U:     enc = {in_imm[31:12], in_rd, opc};
      F_J:     enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
      F_I:     enc = {in_imm[11:0], in_rs1, f3, in_rd, opc};
      F_SH:    enc = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
      F_S:     enc = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
      F_B:     enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
      F_R:     enc = {f7, in_rs2, in_rs1, f3, in_rd, opc};
      default: enc = 32'h0000_0013;
    endcase
  end

`ifdef ENCODE_CHECK_EN
  // An immediate fits its field when every bit above the field equals the field's sign bit.
  always_comb begin
    illegal = 1'b0;
    case (fmt)
      F_U:     illegal = |in_imm[11:0];
      F_J:     illegal = !(&in_imm[31:20] || !(|in_imm[31:20])) || in_imm[0];
      F_I:     illegal = !(&in_imm[31:11] || !(|in_imm[31:11]));
      F_S:     illegal = !(&in_imm[31:11] || !(|in_imm[31:11]));
      F_B:     illegal = !(&in_imm[31:12] || !(|in_imm[31:12])) || in_imm[0];
      F_SH:    illegal = |{in_imm[31:11], in_imm[10] && (in_type != OP_SRAI), in_imm[9:5]};
      F_R:     illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    accept   = 1'b0;
    err      = 1'b0;
    mem_wr   = 1'b0;
    mem_a    = '0;
    mem_dout = 8'h00;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid && !illegal;
        err      = in_valid && illegal;
        if (accept) state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_wr   = 1'b1;
        mem_a    = base + ADDR_WIDTH'(k);
        mem_dout = word[{k, 3'b000} +: 8];
        if (!mem_stall && k == 2'd3) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) state <= S_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      ptr  <= BASE_ADDR;
      base <= '0;
      word <= '0;
      k    <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (addr_load) ptr <= addr_val;
          if (accept) begin
            word <= enc;
            base <= addr_load ? addr_val : ptr;
            k    <= 2'd0;
          end
        end
        S_WRITE: begin
          if (!mem_stall) begin
            if (k == 2'd3) ptr <= base + ADDR_WIDTH'(4);
            k <= k + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: stimulus pushes expected byte writes computed from the
// RV32I field layout; a monitor pops and compares each byte the DUT commits.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int AW = 32;
  localparam logic [AW-1:0] BASE = '0;
`ifdef ENCODE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic              clk_in = 1'b0;
  logic              rstn_in = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [TYPE_W-1:0] in_type = '0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]       in_imm = '0;
  logic              addr_load = 1'b0;
  logic [AW-1:0]     addr_val = '0;
  logic              mem_stall = 1'b0;
  logic [AW-1:0]     mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr, done, err;

  inst_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk_in(clk_in), .rstn_in(rstn_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .addr_load(addr_load), .addr_val(addr_val), .mem_stall(mem_stall),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .done(done), .err(err)
  );

  always #5 clk_in = ~clk_in;

  int n_pass = 0, n_total = 0;
  bit rand_stall = 1'b0;

  typedef enum {M_U, M_J, M_I, M_SH, M_S, M_B, M_R} mfmt_e;
  typedef struct {bit valid; mfmt_e f; int unsigned opc, f3, f7;} isa_t;
  isa_t isa [64];

  typedef struct {logic [AW-1:0] a; logic [7:0] d; bit last;} wr_t;
  wr_t exp_q[$];
  logic [AW-1:0] ptr_m = BASE;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void set_isa(int code, mfmt_e f, int unsigned opc, int unsigned f3, int unsigned f7);
    isa[code] = '{1'b1, f, opc, f3, f7};
  endfunction

  function automatic logic [31:0] model_word(int code, int unsigned rd, int unsigned rs1,
                                             int unsigned rs2, logic [31:0] imm);
    isa_t e = isa[code];
    int unsigned u = imm;
    int unsigned lo = (rd << 7) | e.opc;
    int unsigned mid = (rs1 << 15) | (e.f3 << 12);
    if (!e.valid) return 32'h0000_0013;
    case (e.f)
      M_U:  return (u & 32'hFFFF_F000) | lo;
      M_J:  return (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) |
                   (((u >> 11) & 1) << 20) | (u & 'hFF000) | lo;
      M_I:  return ((u & 'hFFF) << 20) | mid | lo;
      M_SH: return (e.f7 << 25) | ((u & 31) << 20) | mid | lo;
      M_S:  return (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | mid | ((u & 31) << 7) | e.opc;
      M_B:  return (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (rs2 << 20) | mid |
                   (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | e.opc;
      default: return (e.f7 << 25) | (rs2 << 20) | mid | lo;
    endcase
  endfunction

  function automatic bit model_illegal(int code, logic [31:0] imm);
    int s = signed'(imm);
    int unsigned sh = imm;
    if (!isa[code].valid) return 1'b1;
    case (isa[code].f)
      M_I, M_S: return s < -2048 || s > 2047;
      M_B:      return s < -4096 || s > 4094 || s[0];
      M_J:      return s < -1048576 || s > 1048574 || s[0];
      M_U:      return (imm & 32'hFFF) != 0;
      M_SH: begin
        if (code == int'(OP_SRAI)) sh = sh & ~32'h400;
        return sh > 31;
      end
      default:  return 1'b0;
    endcase
  endfunction

  task automatic send(int code, int unsigned rd, int unsigned rs1, int unsigned rs2,
                      logic [31:0] imm, bit load = 1'b0, logic [AW-1:0] lval = '0,
                      bit has_w = 1'b0, logic [31:0] spec_w = '0);
    int guard = 0;
    logic [31:0] w;
    bit bad;
    @(negedge clk_in);
    while (!in_ready && guard < 100) begin @(negedge clk_in); guard++; end
    check("ready_wait", in_ready, 1);
    in_valid = 1'b1; in_type = TYPE_W'(code);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
    addr_load = load; addr_val = lval;
    bad = CHECK_EN && model_illegal(code, imm);
    w = has_w ? spec_w : model_word(code, rd, rs1, rs2, imm);
    if (load) ptr_m = lval;
    if (!bad) begin
      for (int b = 0; b < 4; b++) exp_q.push_back('{ptr_m + AW'(b), w[8*b +: 8], b == 3});
      ptr_m = ptr_m + AW'(4);
    end
    #1 check("err", err, bad);
    @(posedge clk_in);
    #1 in_valid = 1'b0; addr_load = 1'b0;
  endtask

  task automatic load_ptr(logic [AW-1:0] v);
    @(negedge clk_in);
    while (!in_ready) @(negedge clk_in);
    addr_load = 1'b1; addr_val = v;
    @(posedge clk_in);
    #1 addr_load = 1'b0;
    ptr_m = v;
  endtask

  // Called right after an accept edge; returns the cycle (1-based) in which done is seen.
  task automatic time_done(int s_from, int s_to, output int t_done);
    t_done = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(posedge clk_in);
      #1 mem_stall = (c >= s_from && c <= s_to);
      @(negedge clk_in);
      if (done) begin t_done = c; break; end
    end
  endtask

  // Monitor: every byte the DUT commits must match the front of the scoreboard.
  initial forever begin
    @(negedge clk_in);
    if (rstn_in) begin
      if (mem_wr) begin
        check("in_ready_busy", in_ready, 0);
        if (exp_q.size() == 0) check("unexpected_write", mem_wr, 0);
        else begin
          check("mem_a", mem_a, exp_q[0].a);
          check("mem_dout", mem_dout, exp_q[0].d);
          check("done", done, !mem_stall && exp_q[0].last);
          if (!mem_stall) void'(exp_q.pop_front());
        end
      end else begin
        check("done_idle", done, 0);
      end
    end
  end

  initial forever begin
    @(posedge clk_in);
    #2 if (rand_stall) mem_stall = ($urandom_range(0, 3) == 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    logic [31:0] imm;
    set_isa(int'(OP_LUI), M_U, 'h37, 0, 0);   set_isa(int'(OP_AUIPC), M_U, 'h17, 0, 0);
    set_isa(int'(OP_JAL), M_J, 'h6F, 0, 0);   set_isa(int'(OP_JALR), M_I, 'h67, 0, 0);
    set_isa(int'(OP_BEQ), M_B, 'h63, 0, 0);   set_isa(int'(OP_BNE), M_B, 'h63, 1, 0);
    set_isa(int'(OP_BLT), M_B, 'h63, 4, 0);   set_isa(int'(OP_BGE), M_B, 'h63, 5, 0);
    set_isa(int'(OP_BLTU), M_B, 'h63, 6, 0);  set_isa(int'(OP_BGEU), M_B, 'h63, 7, 0);
    set_isa(int'(OP_LB), M_I, 'h03, 0, 0);    set_isa(int'(OP_LH), M_I, 'h03, 1, 0);
    set_isa(int'(OP_LW), M_I, 'h03, 2, 0);    set_isa(int'(OP_LBU), M_I, 'h03, 4, 0);
    set_isa(int'(OP_LHU), M_I, 'h03, 5, 0);   set_isa(int'(OP_SB), M_S, 'h23, 0, 0);
    set_isa(int'(OP_SH), M_S, 'h23, 1, 0);    set_isa(int'(OP_SW), M_S, 'h23, 2, 0);
    set_isa(int'(OP_ADDI), M_I, 'h13, 0, 0);  set_isa(int'(OP_SLTI), M_I, 'h13, 2, 0);
    set_isa(int'(OP_SLTIU), M_I, 'h13, 3, 0); set_isa(int'(OP_XORI), M_I, 'h13, 4, 0);
    set_isa(int'(OP_ORI), M_I, 'h13, 6, 0);   set_isa(int'(OP_ANDI), M_I, 'h13, 7, 0);
    set_isa(int'(OP_SLLI), M_SH, 'h13, 1, 0); set_isa(int'(OP_SRLI), M_SH, 'h13, 5, 0);
    set_isa(int'(OP_SRAI), M_SH, 'h13, 5, 'h20);
    set_isa(int'(OP_ADD), M_R, 'h33, 0, 0);   set_isa(int'(OP_SUB), M_R, 'h33, 0, 'h20);
    set_isa(int'(OP_SLL), M_R, 'h33, 1, 0);   set_isa(int'(OP_SLT), M_R, 'h33, 2, 0);
    set_isa(int'(OP_SLTU), M_R, 'h33, 3, 0);  set_isa(int'(OP_XOR), M_R, 'h33, 4, 0);
    set_isa(int'(OP_SRL), M_R, 'h33, 5, 0);   set_isa(int'(OP_SRA), M_R, 'h33, 5, 'h20);
    set_isa(int'(OP_OR), M_R, 'h33, 6, 0);    set_isa(int'(OP_AND), M_R, 'h33, 7, 0);

    // Reset state.
    #12;
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_dout", mem_dout, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk_in); rstn_in = 1'b1;

    // ADDI x1,x0,-1 right after reset: bytes at 0..3, done in cycle 4, ready again in cycle 5.
    send(int'(OP_ADDI), 1, 0, 0, 32'hFFFF_FFFF, 1'b0, '0, 1'b1, 32'hFFF0_0093);
    time_done(0, -1, t);
    check("latency_done", t, 4);
    @(negedge clk_in);
    check("ready_cycle5", in_ready, 1);

    send(int'(OP_LUI), 5, 0, 0, 32'h1234_5000, 1'b1, 32'h100, 1'b1, 32'h1234_52B7);

    // SRAI with a 3-cycle stall on byte 2: done moves from cycle 4 to 7.
    send(int'(OP_SRAI), 3, 3, 0, 32'd4, 1'b0, '0, 1'b1, 32'h4041_D193);
    time_done(3, 5, t);
    check("stall_done_cycle", t, 7);

    send(int'(OP_BEQ), 0, 1, 2, 32'hFFFF_FFF8, 1'b0, '0, 1'b1, 32'hFE20_8CE3);

    // Reset during byte 1: outputs drop at once and the pointer returns to BASE.
    send(int'(OP_ADDI), 2, 3, 0, 32'd100);
    @(posedge clk_in);
    #2 rstn_in = 1'b0;
    #1;
    check("abort_mem_wr", mem_wr, 0);
    check("abort_mem_a", mem_a, 0);
    check("abort_mem_dout", mem_dout, 0);
    check("abort_done", done, 0);
    check("abort_in_ready", in_ready, 1);
    exp_q.delete();
    ptr_m = BASE;
    @(negedge clk_in); rstn_in = 1'b1;
    send(int'(OP_ADD), 4, 5, 6, 32'd0);

    // Immediate boundaries and unknown types.
    send(int'(OP_ADDI), 7, 8, 0, 32'd2047);
    send(int'(OP_ADDI), 7, 8, 0, -32'sd2048);
    send(int'(OP_ADDI), 7, 8, 0, 32'd2048);
    send(int'(OP_SW), 0, 9, 10, -32'sd2048);
    send(int'(OP_BNE), 0, 11, 12, 32'd4094);
    send(int'(OP_BGE), 0, 11, 12, -32'sd4096);
    send(int'(OP_BLT), 0, 11, 12, 32'd7);
    send(int'(OP_JAL), 1, 0, 0, 32'd1048574);
    send(int'(OP_JAL), 1, 0, 0, -32'sd1048576);
    send(int'(OP_AUIPC), 9, 0, 0, 32'hABCD_E123);
    send(int'(OP_SRAI), 4, 5, 0, 32'h405);
    send(int'(OP_SLLI), 4, 5, 0, 32'd33);
    send(int'(OP_SUB), 13, 14, 15, 32'd0);
    send(int'(OP_SRA), 13, 14, 15, 32'd0);
    send(0, 1, 2, 3, 32'd5);
    send(63, 1, 2, 3, 32'd5);

    // Pointer wrap, then addr_load pulses during a write are ignored.
    load_ptr(32'hFFFF_FFFE);
    send(int'(OP_ORI), 21, 22, 0, 32'h0000_0555);
    send(int'(OP_XOR), 1, 2, 3, 32'd0);
    addr_load = 1'b1; addr_val = 32'hDEAD_0000;
    repeat (2) @(posedge clk_in);
    #1 addr_load = 1'b0;
    send(int'(OP_LW), 6, 7, 0, 32'd16);

    // Randomized ops with random stalls and occasional pointer loads.
    rand_stall = 1'b1;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($signed($urandom) >>> $urandom_range(11, 30));
        2: imm = $urandom & 32'hFFFF_F000;
        default: imm = $urandom_range(0, 40);
      endcase
      send(int'($urandom_range(0, 39)), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), imm, $urandom_range(0, 9) == 0, $urandom);
    end

    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk_in);
    check("queue_drained", exp_q.size(), 0);
    rand_stall = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
